stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-input, WIDTH-bit stream multiplexer with valid/ready handshakes and one registered output stage. Selects one source per cycle either by an explicit select input (fixed mode) or by a fair round-robin arbiter (RR mode). It sits between several producer datapaths and a single downstream consumer, and is the handshaked successor to the team's plain 2:1 byte multiplexer.

## Interface
- WIDTH, 8, data width per channel in bits (≥1)
- N, 4, number of input channels (≥2)
- SW, $clog2(N), select/source-index width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk edge
- mode  in  1  0 = fixed select, 1 = round-robin
- sel  in  SW  channel index used in fixed mode
- in_valid  in  N  per-channel valid; bit i belongs to channel i
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel ready (combinational)
- out_valid  out  1  output register holds a beat
- out_data  out  WIDTH  registered data
- out_src  out  SW  index of the channel that supplied out_data
- out_ready  in  1  downstream accepts beat when out_valid && out_ready

## Operation
- Output stage: a single register {out_valid, out_data, out_src}.
- load_en = !out_valid || out_ready (register is empty or draining this cycle).
- Chosen channel c (combinational):
  - mode=0: c = sel; if sel ≥ N, no channel chosen.
  - mode=1: c = first i with in_valid[i]=1, scanning ptr, ptr+1, … wrapping mod N; none if all in_valid=0.
- in_ready[c] = load_en; all other in_ready bits = 0. In fixed mode in_ready[sel] follows load_en regardless of in_valid[sel].
- Transfer on channel c when in_valid[c] && in_ready[c]; at that edge out_data←in_data[c], out_src←c, out_valid←1.
- No transfer and out_ready=1 (or out_valid=0): out_valid←0; out_data/out_src hold last value.
- No transfer and out_valid=1, out_ready=0: register holds (stall); all in_ready=0.
- RR pointer ptr (SW bits): on a transfer in mode=1, ptr←(c+1) mod N (wrap from N-1 to 0). Transfers in mode=0 do not move ptr.
- mode or sel changes take effect in the same cycle; ptr is retained across mode changes.
- A beat already in the output register is never altered or dropped by mode/sel changes.

## Timing
- Reset (rst_n=0 at edge): out_valid=0, out_data=0, out_src=0, ptr=0. in_ready is combinational: with out_valid=0 after reset, in_ready[c]=1 for the chosen channel once rst_n=1. During reset all in_ready=0.
- Reset mid-operation: any held beat is discarded; no transfer is counted in the reset cycle.
- Latency: input beat accepted at edge k appears on out_data/out_valid after edge k (1 cycle).
- Throughput: one beat per cycle while out_ready=1 and a chosen channel is valid (simultaneous drain and load in the same cycle).
- Fairness: in mode=1 with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,… with no channel waiting more than N-1 transfers.
- Simultaneous events: drain and load in the same edge is a normal pass-through, not a stall.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_src=0, in_ready=0; after release, first beat from channel 0 (ptr=0, mode=1).
- Fixed mode: N=4, mode=0, sel=2, in_data[2]=8'hA5, in_valid=4'b0100, out_ready=1 → in_ready=4'b0100, next cycle out_data=8'hA5, out_src=2, out_valid=1.
- RR fairness: mode=1, in_valid=4'b1111, data channel i = 8'h10+i, out_ready=1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3, out_data 8'h10..8'h13 repeating.
- RR skip and wrap: ptr=3, in_valid=4'b0010 → grant 1, ptr becomes 2; then in_valid=4'b1001 → grant 3, ptr wraps to 0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with inputs changing → out_data/out_src stable, in_ready=0; raise out_ready → held beat consumed, new beat loaded same edge.
- Mode switch: mid-stream switch mode 1→0 with sel=1, then back to 1 → ptr unchanged by fixed-mode transfers; RR resumes from saved ptr.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// N-input, WIDTH-bit valid/ready stream multiplexer with one registered
// output stage. The source channel is picked either by an explicit select
// (mode=0) or by a round-robin arbiter that starts scanning at a rotating
// pointer (mode=1).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   mode       0 = fixed select, 1 = round-robin
//   sel        channel index used in fixed mode
//   in_valid   per-channel valid, bit i = channel i
//   in_data    channel i at bits [i*WIDTH +: WIDTH]
//   in_ready   per-channel ready (combinational, only the chosen channel)
//   out_valid  output register holds a beat
//   out_data   registered data
//   out_src    channel index that supplied out_data
//   out_ready  downstream accepts the beat when out_valid && out_ready
module stream_mux_rr #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SW-1:0]      out_src,
  input  logic               out_ready
);

  logic             load_en_s;
  logic             rr_found_s;
  logic [SW-1:0]    rr_idx_s;
  logic [SW-1:0]    cand_s;
  logic             sel_ok_s;
  logic             chosen_vld_s;
  logic [SW-1:0]    chosen_idx_s;
  logic [WIDTH-1:0] chosen_data_s;
  logic             xfer_s;
  logic [SW-1:0]    ptr_r;
  logic [WIDTH-1:0] ch_data_s [N];

  // The register can take a new beat when it is empty or being drained now.
  assign load_en_s = !out_valid || out_ready;

  // sel may exceed N-1 when N is not a power of two; such a select picks nothing.
  assign sel_ok_s = (int'(sel) < N);

  // Split the flat input data bus into per-channel words.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ch_data_s[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin scan: first valid channel at or after ptr, wrapping mod N.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    cand_s     = '0;
    for (int k = 0; k < N; k++) begin
      cand_s = SW'((int'(ptr_r) + k) % N);
      if (!rr_found_s && in_valid[cand_s]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = cand_s;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Pick the channel for this cycle according to mode.
  always_comb begin
    chosen_vld_s = 1'b0;
    chosen_idx_s = '0;
    if (mode) begin
      chosen_vld_s = rr_found_s;
      chosen_idx_s = rr_idx_s;
    end else begin
      chosen_vld_s = sel_ok_s;
      chosen_idx_s = sel;
    end
  end

  assign chosen_data_s = ch_data_s[chosen_idx_s];

  // Only the chosen channel sees ready; in fixed mode this is independent
  // of that channel's valid so a producer can wait on ready.
  always_comb begin
    in_ready = '0;
    if (rst_n && chosen_vld_s && load_en_s) begin
      in_ready[chosen_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  assign xfer_s = rst_n && chosen_vld_s && load_en_s && in_valid[chosen_idx_s];

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr_r     <= '0;
    end else begin
      if (xfer_s) begin
        out_valid <= 1'b1;
        out_data  <= chosen_data_s;
        out_src   <= chosen_idx_s;
      end else if (load_en_s) begin
        // Drained (or already empty) with nothing new: data/src keep last value.
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
      // Only round-robin grants advance the pointer; fixed-mode traffic leaves it.
      if (xfer_s && mode) begin
        if (chosen_idx_s == SW'(N - 1)) begin
          ptr_r <= '0;
        end else begin
          ptr_r <= chosen_idx_s + SW'(1);
        end
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr (N=4, WIDTH=8): reset checks, a
// hand-computed vector table covering fairness, skip/wrap, backpressure and
// mode switching, hand sequences for fixed select and mid-stream reset, and
// a randomized run against a behavioural reference model.
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         mode;
  logic [1:0]   sel;
  logic [3:0]   in_valid;
  logic [31:0]  in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [7:0]   out_data;
  logic [1:0]   out_src;
  logic         out_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  stream_mux_rr #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // ---------------- reference model ----------------
  int         m_ptr = 0;
  bit         m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_src = 0;
  // values captured before the edge
  int         p_c;
  bit         p_xfer;
  bit         p_load;
  bit         p_rst;
  bit         p_mode;
  logic [7:0] p_data;
  logic [3:0] p_ready;

  // Chosen channel: fixed select, or valid channel at smallest forward distance from ptr.
  function automatic int pick();
    int best = -1;
    int bestd = N;
    if (!mode) return (int'(sel) < N) ? int'(sel) : -1;
    for (int i = 0; i < N; i++) begin
      int d = (i - m_ptr + N) % N;
      if (in_valid[i] && d < bestd) begin
        best = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic model_comb();
    p_rst  = !rst_n;
    p_mode = mode;
    p_load = !m_valid || out_ready;
    p_c    = pick();
    p_ready = 4'b0000;
    if (!p_rst && p_c >= 0 && p_load) p_ready = 4'(1 << p_c);
    p_xfer = (p_c >= 0) && p_ready[p_c] && in_valid[p_c];
    p_data = (p_c >= 0) ? in_data[p_c*8 +: 8] : 8'h00;
  endtask

  task automatic model_commit();
    if (p_rst) begin
      m_valid = 1'b0; m_data = 8'h00; m_src = 0; m_ptr = 0;
    end else if (p_xfer) begin
      m_valid = 1'b1; m_data = p_data; m_src = p_c;
      if (p_mode) m_ptr = (p_c + 1) % N;
    end else if (p_load) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: inputs were driven just after a negedge.
  task automatic tick();
    #1;
    model_comb();
    chk("model_in_ready", 32'(in_ready), 32'(p_ready));
    @(posedge clk);
    #1;
    model_commit();
    chk("model_out_valid", 32'(out_valid), 32'(m_valid));
    chk("model_out_data", 32'(out_data), 32'(m_data));
    chk("model_out_src", 32'(out_src), 32'(m_src));
    @(negedge clk);
  endtask

  task automatic set_std_data();
    for (int i = 0; i < N; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       mode;
    logic [1:0] sel;
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [1:0] e_src;
    logic [7:0] e_data;
  } vec_t;

  vec_t tab [25];

  initial begin
    // RR fairness, all channels valid
    tab[0]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tab[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tab[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tab[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tab[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tab[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tab[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tab[7]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    // reach ptr=3, then skip to 1 (ptr->2), then 1001 -> 3 (ptr wraps 0)
    tab[8]  = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tab[9]  = '{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tab[10] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tab[11] = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    // backpressure for 3 cycles with changing inputs, then drain+load
    tab[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
    tab[13] = '{1'b1, 2'd0, 4'b0110, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
    tab[14] = '{1'b0, 2'd3, 4'b1000, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
    tab[15] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    // mode switch to fixed sel=1, ready without valid, then back to RR at ptr=2
    tab[16] = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tab[17] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd1, 8'h11};
    tab[18] = '{1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tab[19] = '{1'b1, 2'd1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tab[20] = '{1'b1, 2'd1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tab[21] = '{1'b1, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h13};
    // fixed-mode transfer of channel 0 must not move ptr (still 0)
    tab[22] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 8'h10};
    tab[23] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 8'h10};
    tab[24] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
  end

  initial begin
    rst_n = 1'b0;
    mode = 1'b1;
    sel = 2'd0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    in_data = 32'h0;
    set_std_data();
    @(negedge clk);

    // ---- reset held 2 cycles with all channels valid ----
    for (int r = 0; r < 2; r++) begin
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_out_data", 32'(out_data), 32'h0);
      chk("rst_out_src", 32'(out_src), 32'h0);
    end
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < 25; i++) begin
      mode = tab[i].mode;
      sel = tab[i].sel;
      in_valid = tab[i].vld;
      out_ready = tab[i].ordy;
      #1;
      chk($sformatf("tab%0d_in_ready", i), 32'(in_ready), 32'(tab[i].e_rdy));
      tick();
      chk($sformatf("tab%0d_out_valid", i), 32'(out_valid), 32'(tab[i].e_ov));
      chk($sformatf("tab%0d_out_src", i), 32'(out_src), 32'(tab[i].e_src));
      chk($sformatf("tab%0d_out_data", i), 32'(out_data), 32'(tab[i].e_data));
    end

    // ---- fixed mode, sel=2, data A5 ----
    in_data[2*8 +: 8] = 8'hA5;
    mode = 1'b0;
    sel = 2'd2;
    in_valid = 4'b0100;
    out_ready = 1'b1;
    #1;
    chk("fix_in_ready", 32'(in_ready), 32'h4);
    tick();
    chk("fix_out_valid", 32'(out_valid), 32'h1);
    chk("fix_out_data", 32'(out_data), 32'hA5);
    chk("fix_out_src", 32'(out_src), 32'h2);
    set_std_data();

    // ---- reset mid-operation discards a held beat and ptr ----
    mode = 1'b1;
    in_valid = 4'b1111;
    tick();
    out_ready = 1'b0;
    tick();
    chk("mid_held_valid", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_post_ready", 32'(in_ready), 32'h1);
    tick();
    chk("mid_post_src", 32'(out_src), 32'h0);
    chk("mid_post_data", 32'(out_data), 32'h10);

    // ---- randomized run against the model ----
    for (int n = 0; n < 400; n++) begin
      mode = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) in_data[i*8 +: 8] = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
